// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite to APB bridge path.
// Holds the transfer data types, response codes and the APB master state encoding.
package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    function automatic resp_t resp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/apb_master_fsm.sv
// APB4 master: takes one command at a time from the AXI-Lite front end,
// runs SETUP/ACCESS on APB with a bounded wait, and returns a held completion.
module apb_master_fsm
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [2:0]          req_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output resp_t               rsp_resp,
    output logic [ADDR_W-1:0]   paddr,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [2:0]          pprot,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int         STRB_W     = DATA_W / 8;
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    apb_state_e          state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [2:0]          pprot_q, pprot_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    resp_t               rsp_resp_q, rsp_resp_d;
    logic                slv_err_s;

    // Error is only meaningful on the completing beat of a live transfer.
    assign slv_err_s = psel_q & penable_q & pready & pslverr;

    // Next-state, command capture and response capture.
    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d  = ST_SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : {DATA_W{1'b0}};
                    pstrb_d  = req_write ? req_strb : {STRB_W{1'b0}};
                    pprot_d  = req_prot;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                psel_d     = 1'b1;
                penable_d  = 1'b1;
                wait_cnt_d = 8'd0;
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_rdata_d = pwrite_q ? {DATA_W{1'b0}} : prdata;
                    rsp_resp_d  = resp_from_err(slv_err_s);
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    // Slave never answered: fail the transfer rather than hang the bus.
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    rsp_rdata_d = {DATA_W{1'b0}};
                    rsp_resp_d  = RESP_SLVERR;
                end else begin
                    psel_d     = 1'b1;
                    penable_d  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including req_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            paddr_q     <= {ADDR_W{1'b0}};
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DATA_W{1'b0}};
            pstrb_q     <= {STRB_W{1'b0}};
            pprot_q     <= 3'd0;
            wait_cnt_q  <= 8'd0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pprot     = pprot_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Self-checking bench for apb_master_fsm: directed vector table, hand-written
// reset/backpressure sequences, and random transfers against a transaction model.
module tb_apb_master_fsm;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_master_fsm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;      // pready low cycles before the completing beat
        logic        err;        // pslverr on the completing beat
        logic        noise;      // pslverr while pready is low
        logic [31:0] prdata;
        int          rsp_delay;  // cycles of rsp_ready=0 while response is held
        int          exp_acc;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level prediction from the bridge rules.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        bit   timed_out;
        r         = v;
        timed_out = (v.waits >= TMO);
        r.exp_acc   = timed_out ? TMO : v.waits + 1;
        r.exp_resp  = (timed_out || v.err) ? 2'b10 : 2'b00;
        r.exp_rdata = (!v.write && !timed_out) ? v.prdata : 32'h0;
        return r;
    endfunction

    task automatic chk_apb(input vec_t v);
        chk("paddr", paddr, v.addr);
        chk("pwrite", pwrite, v.write);
        chk("pwdata", pwdata, v.write ? v.wdata : 32'h0);
        chk("pstrb", pstrb, v.write ? v.strb : 4'h0);
        chk("pprot", pprot, v.prot);
    endtask

    task automatic chk_rsp(input vec_t v);
        chk("rsp_write", rsp_write, v.write);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", rsp_resp, v.exp_resp);
    endtask

    // Runs one full transfer; called at a negedge with the block idle or about to be.
    task automatic run_txn(input vec_t v);
        int cyc;
        int acc;
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
        req_wdata = v.wdata; req_strb = v.strb; req_prot = v.prot;
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", cyc);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk("setup_psel", psel, 1'b1);
        chk("setup_penable", penable, 1'b0);
        chk_apb(v);
        @(negedge clk);
        acc = 0;
        while (psel && penable && acc < 300) begin
            acc++;
            chk_apb(v);
            pready  = (acc == v.waits + 1);
            pslverr = pready ? v.err : v.noise;
            prdata  = pready ? v.prdata : $urandom;
            @(negedge clk);
        end
        pready = 1'b0; pslverr = 1'b0;
        chk("access_cycles", acc, v.exp_acc);
        chk("resp_psel", psel, 1'b0);
        chk("resp_penable", penable, 1'b0);
        chk("resp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < v.rsp_delay; i++) begin
            chk("held_req_ready", req_ready, 1'b0);
            chk_rsp(v);
            @(negedge clk);
            chk("held_valid", rsp_valid, 1'b1);
        end
        chk_rsp(v);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_valid", rsp_valid, 1'b0);
        chk("done_req_ready", req_ready, 1'b1);
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 32'h40,  32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 1'b0, 32'h0,        0, 1, 2'b00, 32'h0};
        tbl[1] = '{1'b0, 32'h80,  32'h0,        4'h0, 3'd0, 3, 1'b0, 1'b0, 32'h12345678, 0, 4, 2'b00, 32'h12345678};
        tbl[2] = '{1'b1, 32'h100, 32'h0BADF00D, 4'h3, 3'd2, 2, 1'b1, 1'b1, 32'h0,        1, 3, 2'b10, 32'h0};
        tbl[3] = '{1'b0, 32'h104, 32'h0,        4'h0, 3'd1, 2, 1'b0, 1'b1, 32'hA5A5A5A5, 0, 3, 2'b00, 32'hA5A5A5A5};
        tbl[4] = '{1'b0, 32'h200, 32'h0,        4'h0, 3'd0, 9, 1'b0, 1'b0, 32'hFFFFFFFF, 2, 4, 2'b10, 32'h0};
        tbl[5] = '{1'b1, 32'h44,  32'h11112222, 4'h0, 3'd0, 0, 1'b0, 1'b0, 32'h0,        0, 1, 2'b00, 32'h0};
        tbl[6] = '{1'b0, 32'hC0,  32'hFFFF0000, 4'hF, 3'd5, 0, 1'b0, 1'b0, 32'h600D600D, 5, 1, 2'b00, 32'h600D600D};
        tbl[7] = '{1'b0, 32'hC4,  32'h0,        4'h0, 3'd7, 1, 1'b1, 1'b0, 32'hCAFE0001, 0, 2, 2'b10, 32'hCAFE0001};
        tbl[8] = '{1'b1, 32'h208, 32'h1,        4'h1, 3'd0, 4, 1'b0, 1'b0, 32'h0,        0, 4, 2'b10, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_strb = 4'h0; req_prot = 3'd0; rsp_ready = 1'b0;
        prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

        // Reset state and first-edge req_ready.
        repeat (2) @(negedge clk);
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_rsp_resp", rsp_resp, 2'b00);
        rst_n = 1'b1;
        chk("rel_req_ready", req_ready, 1'b0);
        @(negedge clk);
        chk("first_edge_req_ready", req_ready, 1'b1);

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // Request offered while busy waits for IDLE and is not dropped.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h500; req_wdata = 32'h55;
        req_strb = 4'hF; req_prot = 3'd0;
        @(negedge clk);
        req_write = 1'b0; req_addr = 32'h504;
        chk("busy_a_paddr", paddr, 32'h500);
        @(negedge clk);
        pready = 1'b1;
        @(negedge clk);
        pready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_req_ready", req_ready, 1'b0);
            chk("busy_psel", psel, 1'b0);
            chk("busy_rsp_valid", rsp_valid, 1'b1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("busy_idle_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_b_psel", psel, 1'b1);
        chk("busy_b_paddr", paddr, 32'h504);
        chk("busy_b_pwrite", pwrite, 1'b0);
        @(negedge clk);
        pready = 1'b1; prdata = 32'h77;
        @(negedge clk);
        pready = 1'b0;
        chk("busy_b_valid", rsp_valid, 1'b1);
        chk("busy_b_rdata", rsp_rdata, 32'h77);
        chk("busy_b_write", rsp_write, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset pulsed in the middle of ACCESS.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", psel, 1'b0);
        chk("mid_rst_penable", penable, 1'b0);
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_paddr", paddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1'b1);
        run_txn(tbl[0]);

        // Random transfers against the transaction model.
        for (int i = 0; i < 40; i++) begin
            rv.write     = 1'($urandom_range(0, 1));
            rv.addr      = $urandom;
            rv.wdata     = $urandom;
            rv.strb      = 4'($urandom_range(0, 15));
            rv.prot      = 3'($urandom_range(0, 7));
            rv.waits     = $urandom_range(0, 6);
            rv.err       = 1'($urandom_range(0, 1));
            rv.noise     = 1'($urandom_range(0, 1));
            rv.prdata    = $urandom;
            rv.rsp_delay = $urandom_range(0, 3);
            rv = predict(rv);
            run_txn(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
